// File: rtl/mux_8way_16_pkg.sv
// ---------------------------------------------------------------------------
// mux_8way_16_pkg
// Shared constants and types for the eight-way, 16-bit word selector.
//   WIDTH    : data word width in bits (16)
//   WAYS     : number of selectable inputs (8)
//   SEL_W    : select width, log2(WAYS) (3)
//   word_t   : one data word
//   sel_t    : way index
//   WORD_RST : value the optional output register takes on reset
// ---------------------------------------------------------------------------
package mux_8way_16_pkg;

  localparam int WIDTH = 16;
  localparam int WAYS  = 8;
  localparam int SEL_W = 3;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SEL_W-1:0] sel_t;

  localparam word_t WORD_RST = 16'h0000;

endpackage : mux_8way_16_pkg

// File: rtl/mux_2way_16.sv
// ---------------------------------------------------------------------------
// mux_2way_16
// Two-input, 16-bit word selector: out = sel ? b : a.
// The conditional operator is kept on purpose so an X/Z select merges the
// two words bitwise in simulation instead of silently picking one of them.
// Ports:
//   a   in  16  word chosen when sel = 0
//   b   in  16  word chosen when sel = 1
//   sel in   1  select
//   out out 16  selected word
// ---------------------------------------------------------------------------
module mux_2way_16
  import mux_8way_16_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  sel,
  output word_t out
);

  assign out = sel ? b : a;

endmodule : mux_2way_16

// File: rtl/mux_8way_16.sv
// ---------------------------------------------------------------------------
// mux_8way_16
// Eight-input, 16-bit word selector built as a balanced tree of seven
// mux_2way_16 cells: sel[0] picks within pairs, sel[1] within the resulting
// pairs, sel[2] picks the final word.
//
// Build option MUX_8WAY_16_OUT_REG_EN:
//   defined   -> out is registered on posedge clk (1-cycle latency), and an
//                asynchronous active-high rst forces out to WORD_RST.
//   undefined -> out is purely combinational; clk and rst are unused.
// The port list is the same in both builds.
//
// Ports:
//   clk in   1          clock (registered build only)
//   rst in   1          async active-high reset (registered build only)
//   in  in   [7:0][15:0] eight words, in[i] is way i
//   sel in   3          way index 0..7
//   out out  16         selected word
// ---------------------------------------------------------------------------
module mux_8way_16
  import mux_8way_16_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WAYS-1:0][WIDTH-1:0]  in,
  input  sel_t                        sel,
  output word_t                       out
);

  word_t lvl1 [4];
  word_t lvl2 [2];
  word_t mux_out;

  // Level 1: pairs (0,1) (2,3) (4,5) (6,7) resolved by sel[0].
  for (genvar i = 0; i < 4; i++) begin : g_lvl1
    mux_2way_16 u_mux (
      .a   (in[2*i]),
      .b   (in[2*i+1]),
      .sel (sel[0]),
      .out (lvl1[i])
    );
  end

  // Level 2: resolved by sel[1].
  for (genvar i = 0; i < 2; i++) begin : g_lvl2
    mux_2way_16 u_mux (
      .a   (lvl1[2*i]),
      .b   (lvl1[2*i+1]),
      .sel (sel[1]),
      .out (lvl2[i])
    );
  end

  // Level 3: final word resolved by sel[2].
  mux_2way_16 u_lvl3 (
    .a   (lvl2[0]),
    .b   (lvl2[1]),
    .sel (sel[2]),
    .out (mux_out)
  );

`ifdef MUX_8WAY_16_OUT_REG_EN
  word_t out_q;

  // NOTE: flops use non-blocking assignments, and only this single output
  // register carries a reset; the select tree itself holds no state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= WORD_RST;
    else     out_q <= mux_out;
  end

  assign out = out_q;
`else
  // Clock and reset have no function in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign out = mux_out;
`endif

endmodule : mux_8way_16

// File: tb/tb_mux_8way_16.sv
// ---------------------------------------------------------------------------
// tb_mux_8way_16
// Scoreboard bench for mux_8way_16. Stimulus drives in/sel just after a
// rising edge and queues the expected word with the cycle in which it must
// appear (same cycle when combinational, next cycle when registered). A
// monitor on the falling edge pops and compares every entry that is due.
// Follows MUX_8WAY_16_OUT_REG_EN to pick the latency and the reset checks.
// ---------------------------------------------------------------------------
module tb_mux_8way_16;
  import mux_8way_16_pkg::*;

`ifdef MUX_8WAY_16_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int    due;
    word_t exp;
    string name;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [WAYS-1:0][WIDTH-1:0] din = '0;
  sel_t                       sel = '0;
  word_t                      out;

  exp_t  sb [$];
  int    cyc     = 0;
  int    n_check = 0;
  int    n_fail  = 0;

  word_t base_w [8] = '{16'haabb, 16'hccdd, 16'h1122, 16'h3344,
                        16'h5566, 16'h7788, 16'h9900, 16'h0000};

  mux_8way_16 dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .sel (sel),
    .out (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, out, e.exp);
    end
  end

  task automatic load_base();
    for (int i = 0; i < 8; i++) din[i] = base_w[i];
  endtask

  // Drive one vector after the next rising edge and queue its expectation.
  task automatic apply(input sel_t s, input word_t exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    sel   = s;
    e.due  = cyc + LAT;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 6 && sb.size() != 0; k++) @(negedge clk);
    #1;
    check("scoreboard_drained", word_t'(sb.size()), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    load_base();
    sel = 3'd0;
    #1;
`ifdef MUX_8WAY_16_OUT_REG_EN
    check("reset_out_zero", out, WORD_RST);
`else
    check("comb_at_t1", out, 16'haabb);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: sweep every select code on the reference words.
    for (int i = 0; i < 8; i++) apply(sel_t'(i), base_w[i], $sformatf("sweep_sel%0d", i));
    drain();

    // 2: wrap-around 7 -> 0 repeatedly.
    for (int i = 0; i < 1000; i++) apply(sel_t'(i % 8), base_w[i % 8], "wrap");
    drain();

    // 3: data change on the selected way, then on an unselected way.
    apply(3'd3, 16'h3344, "fixed_sel_before");
    @(posedge clk);
    #1;
    din[3] = 16'hffff;
`ifndef MUX_8WAY_16_OUT_REG_EN
    #1;
    check("data_change_immediate", out, 16'hffff);
`endif
    begin
      exp_t e;
      e.due = cyc + LAT; e.exp = 16'hffff; e.name = "data_change_sel3";
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    din[5] = 16'h1234;
    din[0] = 16'h5a5a;
    begin
      exp_t e;
      e.due = cyc + LAT; e.exp = 16'hffff; e.name = "other_way_change";
      sb.push_back(e);
    end
    drain();
    load_base();

    // 4: latency / stale value around a select change.
    apply(3'd6, 16'h9900, "latency_prev_word");
    apply(3'd2, 16'h1122, "latency_sel2");
    drain();

`ifdef MUX_8WAY_16_OUT_REG_EN
    // 5: asynchronous reset mid-cycle while out holds 7788.
    apply(3'd5, 16'h7788, "pre_reset_7788");
    drain();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", out, WORD_RST);
    sel = 3'd1;
    @(posedge clk);
    #1;
    check("reset_held", out, WORD_RST);
    rst = 1'b0;
    begin
      exp_t e;
      e.due = cyc + 1; e.exp = 16'hccdd; e.name = "post_reset_sel1";
      sb.push_back(e);
    end
    drain();
`endif

    // 6: isolation with a walking one on each way.
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < WIDTH; b++) begin
        din = '0;
        din[w] = word_t'(1) << b;
        for (int s = 0; s < 8; s++)
          apply(sel_t'(s), (s == w) ? (word_t'(1) << b) : 16'h0000, "isolation");
        drain();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule : tb_mux_8way_16
